// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: operand store and skewed wavefront sequencer for a 3x3 systolic array
module systolic_seq_ctrl #(
   parameter int DW           = 32,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_sel,
   input  logic [3:0]    wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          acc_clr,
   output logic          feed_valid,
   output logic [DW-1:0] west0,
   output logic [DW-1:0] west1,
   output logic [DW-1:0] west2,
   output logic [DW-1:0] north0,
   output logic [DW-1:0] north1,
   output logic [DW-1:0] north2
);
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;
   localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
   state_t        state, state_nx;
   logic [2:0]    t, t_nx;
   logic [3:0]    fc, fc_nx;
   logic [DW-1:0] a [9];
   logic [DW-1:0] b [9];
   logic [DW-1:0] wv [3];
   logic [DW-1:0] nv [3];
   // state, wavefront index and flush counter registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         t     <= '0;
         fc    <= '0;
      end else begin
         state <= state_nx;
         t     <= t_nx;
         fc    <= fc_nx;
      end
   // pass sequencing: one clear cycle, five wavefront cycles, flush, one done cycle
   always_comb begin
      state_nx = state;
      t_nx     = t;
      fc_nx    = fc;
      case (state)
         IDLE:  state_nx = start ? CLEAR : IDLE;
         CLEAR: begin
            state_nx = FEED;
            t_nx     = '0;
         end
         FEED:  begin
            state_nx = (t == 3'd4) ? FLUSH : FEED;
            t_nx     = (t == 3'd4) ? t : t + 3'd1;
            fc_nx    = '0;
         end
         FLUSH: begin
            state_nx = (fc == FLUSH_LAST) ? DONE : FLUSH;
            fc_nx    = (fc == FLUSH_LAST) ? fc : fc + 4'd1;
         end
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // operand store; host writes land only while idle and only for indices 0..8
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < 9; i++) begin
            a[i] <= '0;
            b[i] <= '0;
         end
      end else if (wr_en && state == IDLE && wr_addr < 4'd9) begin
         if (wr_sel) b[wr_addr] <= wr_data;
         else        a[wr_addr] <= wr_data;
      end
   // skewed decode: row i gets A[i][t-i] at flat index 2i+t, column j gets B[t-j][j] at 3t-2j
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         wv[i] = '0;
         nv[i] = '0;
         if (state == FEED && t >= 3'(i) && (t - 3'(i)) <= 3'd2) begin
            wv[i] = a[4'(2 * i) + {1'b0, t}];
            nv[i] = b[4'd3 * {1'b0, t} - 4'(2 * i)];
         end
      end
   end
   assign busy       = state != IDLE;
   assign done       = state == DONE;
   assign acc_clr    = state == CLEAR;
   assign feed_valid = state == FEED;
   assign west0      = wv[0];
   assign west1      = wv[1];
   assign west2      = wv[2];
   assign north0     = nv[0];
   assign north1     = nv[1];
   assign north2     = nv[2];
endmodule
